// File: rtl/serializer_pipe.sv
// Parallel-to-serial TX shifter with a one-word holding register and gapless chaining.
// Optional parity bit per frame when SERIALIZER_PARITY_EN is defined.
module serializer_pipe #(
  parameter int DATA_WIDTH = 8,
  parameter bit MSB_FIRST  = 1'b0
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [DATA_WIDTH-1:0] P_DATA,
  input  logic                  data_valid,
  output logic                  data_ready,
  input  logic                  send,
  output logic                  ser_out,
  output logic                  busy,
  output logic                  ser_done
`ifdef SERIALIZER_PARITY_EN
  ,
  input  logic                  par_odd
`endif
);

  localparam int CW = $clog2(DATA_WIDTH);
  localparam logic [CW-1:0] LAST = CW'(DATA_WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    PARITY = 2'd2
  } state_t;

  state_t state_q;
  state_t state_d;

  logic [DATA_WIDTH-1:0] hold_q;
  logic [DATA_WIDTH-1:0] shift_q;
  logic [DATA_WIDTH-1:0] shift_nx;
  logic                  hold_full_q;
  logic [CW-1:0]         cnt_q;
  logic                  done_q;
  logic                  busy_q;
  logic                  par_q;

  logic accept;
  logic load;
  logic advance;
  logic frame_end;
  logic last;

  assign accept = data_valid & ~hold_full_q;
  assign last   = (cnt_q == LAST);

  // Shift toward whichever end feeds ser_out
  always_comb begin
    if (MSB_FIRST) begin
      shift_nx = {shift_q[DATA_WIDTH-2:0], 1'b0};
    end else begin
      shift_nx = {1'b0, shift_q[DATA_WIDTH-1:1]};
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    load      = 1'b0;
    advance   = 1'b0;
    frame_end = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (hold_full_q) begin
          load    = 1'b1;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        if (send) begin
          if (!last) begin
            advance = 1'b1;
          end else begin
`ifdef SERIALIZER_PARITY_EN
            state_d = PARITY;
`else
            frame_end = 1'b1;
`endif
          end
        end
      end
`ifdef SERIALIZER_PARITY_EN
      PARITY: begin
        if (send) begin
          frame_end = 1'b1;
        end
      end
`endif
      default: begin
        state_d = IDLE;
      end
    endcase
    // Frame end chains straight into the held word when one is waiting
    if (frame_end) begin
      if (hold_full_q) begin
        load    = 1'b1;
        state_d = SHIFT;
      end else begin
        state_d = IDLE;
      end
    end
  end

  always_comb begin
    ser_out = 1'b0;
    unique case (state_q)
      SHIFT: begin
        ser_out = MSB_FIRST ? shift_q[DATA_WIDTH-1] : shift_q[0];
      end
      PARITY: begin
        ser_out = par_q;
      end
      default: begin
        ser_out = 1'b0;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      hold_full_q <= 1'b0;
      cnt_q       <= '0;
      done_q      <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      done_q <= frame_end;
      busy_q <= (state_d != IDLE);
      if (load) begin
        hold_full_q <= 1'b0;
      end else if (accept) begin
        hold_full_q <= 1'b1;
      end
      if (load) begin
        cnt_q <= '0;
      end else if (advance) begin
        cnt_q <= cnt_q + 1'b1;
      end
    end
  end

  // Word storage carries no reset; validity lives in hold_full_q and state_q
  always_ff @(posedge CLK) begin
    if (accept) begin
      hold_q <= P_DATA;
    end
    if (load) begin
      shift_q <= hold_q;
    end else if (advance) begin
      shift_q <= shift_nx;
    end
  end

`ifdef SERIALIZER_PARITY_EN
  always_ff @(posedge CLK) begin
    if (load) begin
      par_q <= (^hold_q) ^ par_odd;
    end
  end
`else
  assign par_q = 1'b0;
`endif

  assign data_ready = ~hold_full_q;
  assign busy       = busy_q;
  assign ser_done   = done_q;

endmodule
